// File: rtl/inorder_isq_2w1r.sv
// -----------------------------------------------------------------------------
// inorder_isq_2w1r
//   In-order issue queue for the integer backend. Dispatch can write up to two
//   entries per cycle; the execution unit takes the head entry once all of its
//   condition (operand-ready) bits are set. Writeback ports set condition bits
//   by ROB id. A flush squashes every entry younger than a given ROB id and pulls
//   the tail back to just after the youngest survivor.
//
// Ports
//   clock, reset_n           clock, asynchronous active-low reset
//   enq0_* / enq1_*          two enqueue slots; slot 1 is younger than slot 0
//   enq_ready                at least two free entries and no flush this cycle
//   deq_valid/ready/data/cond head entry issue handshake and contents
//   wb_valid/robid/mask      NUM_WB wakeup ports (packed, port p at [p*W +: W])
//   flush_valid/robid        squash everything strictly younger than flush_robid
//   count, empty, full       occupancy
// -----------------------------------------------------------------------------
module inorder_isq_2w1r #(
    parameter int DEPTH       = 8,
    parameter int DATA_WIDTH  = 248,
    parameter int COND_WIDTH  = 2,
    parameter int ROBID_WIDTH = 7,
    parameter int ROBID_LSB   = 241,
    parameter int NUM_WB      = 2
) (
    input  logic                            clock,
    input  logic                            reset_n,
    input  logic                            enq0_valid,
    input  logic [DATA_WIDTH-1:0]           enq0_data,
    input  logic [COND_WIDTH-1:0]           enq0_cond,
    input  logic                            enq1_valid,
    input  logic [DATA_WIDTH-1:0]           enq1_data,
    input  logic [COND_WIDTH-1:0]           enq1_cond,
    output logic                            enq_ready,
    output logic                            deq_valid,
    input  logic                            deq_ready,
    output logic [DATA_WIDTH-1:0]           deq_data,
    output logic [COND_WIDTH-1:0]           deq_cond,
    input  logic [NUM_WB-1:0]               wb_valid,
    input  logic [NUM_WB*ROBID_WIDTH-1:0]   wb_robid,
    input  logic [NUM_WB*COND_WIDTH-1:0]    wb_mask,
    input  logic                            flush_valid,
    input  logic [ROBID_WIDTH-1:0]          flush_robid,
    output logic [$clog2(DEPTH):0]          count,
    output logic                            empty,
    output logic                            full
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // OR of the masks of every active wakeup port whose ROB id equals id.
    function automatic logic [COND_WIDTH-1:0] wake_hits(
        input logic [ROBID_WIDTH-1:0]        id,
        input logic [NUM_WB-1:0]             v,
        input logic [NUM_WB*ROBID_WIDTH-1:0] ids,
        input logic [NUM_WB*COND_WIDTH-1:0]  masks
    );
        logic [COND_WIDTH-1:0] m;
        m = '0;
        for (int p = 0; p < NUM_WB; p++) begin
            if (v[p] && (ids[p*ROBID_WIDTH +: ROBID_WIDTH] == id)) begin
                m = m | masks[p*COND_WIDTH +: COND_WIDTH];
            end
        end
        return m;
    endfunction

    // ROB ids carry a wrap bit in the MSB; a differing wrap bit inverts the
    // plain index comparison.
    function automatic logic is_younger(
        input logic [ROBID_WIDTH-1:0] e,
        input logic [ROBID_WIDTH-1:0] f
    );
        return (e[ROBID_WIDTH-1] ^ f[ROBID_WIDTH-1]) ^
               (e[ROBID_WIDTH-2:0] > f[ROBID_WIDTH-2:0]);
    endfunction

    logic [DATA_WIDTH-1:0] data_q [DEPTH];
    logic [DATA_WIDTH-1:0] data_d [DEPTH];
    logic [COND_WIDTH-1:0] cond_q [DEPTH];
    logic [COND_WIDTH-1:0] cond_d [DEPTH];
    logic [DEPTH-1:0]      valid_q, valid_d;
    logic [PTR_W-1:0]      head_q, head_d;
    logic [PTR_W-1:0]      tail_q, tail_d;
    logic [CNT_W-1:0]      count_q, count_d;

    logic [DEPTH-1:0][COND_WIDTH-1:0] wake_mask;
    logic [DEPTH-1:0]                 kill;

    // Per-entry wakeup match and flush kill decision.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic [ROBID_WIDTH-1:0] entry_id;
            assign entry_id      = data_q[gi][ROBID_LSB +: ROBID_WIDTH];
            assign wake_mask[gi] = valid_q[gi] ?
                                   wake_hits(entry_id, wb_valid, wb_robid, wb_mask) : '0;
            assign kill[gi]      = valid_q[gi] && is_younger(entry_id, flush_robid);
        end
    endgenerate

    logic [CNT_W:0]   free_slots;
    logic             enq0_fire, enq1_fire, deq_fire;
    logic [1:0]       n_enq;
    logic [PTR_W-1:0] tail_p1;
    logic [CNT_W-1:0] survivors;

    assign free_slots = (CNT_W+1)'(DEPTH) - {1'b0, count_q};
    assign empty      = (count_q == '0);
    assign full       = (count_q == CNT_W'(DEPTH));
    assign count      = count_q;
    assign enq_ready  = (free_slots >= (CNT_W+1)'(2)) && !flush_valid;
    assign deq_valid  = !empty && (&cond_q[head_q]) && !flush_valid;
    assign deq_data   = empty ? '0 : data_q[head_q];
    assign deq_cond   = empty ? '0 : cond_q[head_q];

    assign enq0_fire  = enq_ready && enq0_valid;
    assign enq1_fire  = enq_ready && enq1_valid;
    assign deq_fire   = deq_valid && deq_ready;
    assign n_enq      = {1'b0, enq0_fire} + {1'b0, enq1_fire};
    assign tail_p1    = tail_q + PTR_W'(1);

    always_comb begin
        survivors = '0;
        for (int i = 0; i < DEPTH; i++) begin
            survivors = survivors + CNT_W'(valid_q[i] && !kill[i]);
        end
    end

    always_comb begin
        valid_d = valid_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        for (int i = 0; i < DEPTH; i++) begin
            data_d[i] = data_q[i];
            cond_d[i] = cond_q[i] | wake_mask[i];
        end

        if (flush_valid) begin
            // Survivors are a contiguous run starting at head, so the tail
            // simply lands right after them.
            for (int i = 0; i < DEPTH; i++) begin
                if (kill[i]) begin
                    valid_d[i] = 1'b0;
                    cond_d[i]  = '0;
                end
            end
            count_d = survivors;
            tail_d  = head_q + survivors[PTR_W-1:0];
        end else begin
            if (deq_fire) begin
                valid_d[head_q] = 1'b0;
                cond_d[head_q]  = '0;
                head_d          = head_q + PTR_W'(1);
            end
            // Enqueued entries see same-cycle wakeups for their own ROB id.
            if (enq0_fire) begin
                valid_d[tail_q] = 1'b1;
                data_d[tail_q]  = enq0_data;
                cond_d[tail_q]  = enq0_cond |
                    wake_hits(enq0_data[ROBID_LSB +: ROBID_WIDTH], wb_valid, wb_robid, wb_mask);
            end
            if (enq1_fire) begin
                valid_d[tail_p1] = 1'b1;
                data_d[tail_p1]  = enq1_data;
                cond_d[tail_p1]  = enq1_cond |
                    wake_hits(enq1_data[ROBID_LSB +: ROBID_WIDTH], wb_valid, wb_robid, wb_mask);
            end
            tail_d  = tail_q + PTR_W'(n_enq);
            count_d = count_q + CNT_W'(n_enq) - CNT_W'(deq_fire);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                cond_q[i] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            for (int i = 0; i < DEPTH; i++) begin
                cond_q[i] <= cond_d[i];
            end
        end
    end

    // Payload storage needs no reset: it is only observed through valid entries
    // and the outputs are forced to zero while empty.
    always_ff @(posedge clock) begin
        for (int i = 0; i < DEPTH; i++) begin
            data_q[i] <= data_d[i];
        end
    end

endmodule

// File: doc/inorder_isq_2w1r.md
Name: inorder_isq_2w1r

Overview:
- In-order issue queue for the integer backend: 2-wide enqueue from dispatch, 1-wide in-order dequeue to the execution unit.
- Each entry holds a payload, a per-source condition (operand-ready) vector and a ROB id.
- Condition bits are set by NUM_WB writeback ports, matched by ROB id.
- Branch/exception flush squashes every entry younger than a given ROB id and rolls the tail back, leaving the older entries intact.

Parameters:
- DEPTH, 8, entry count; power of 2, >=4.
- DATA_WIDTH, 248, payload width.
- COND_WIDTH, 2, condition bits per entry; entry is ready when all are 1.
- ROBID_WIDTH, 7, ROB id width; MSB is the wrap bit, low bits are the index.
- ROBID_LSB, 241, ROB id field is data[ROBID_LSB+ROBID_WIDTH-1:ROBID_LSB].
- NUM_WB, 2, number of writeback/wakeup ports.

Ports:
- clock  in  1  clock
- reset_n  in  1  reset
- enq0_valid  in  1  slot-0 enqueue request
- enq0_data  in  DATA_WIDTH  slot-0 payload
- enq0_cond  in  COND_WIDTH  slot-0 initial condition
- enq1_valid  in  1  slot-1 enqueue request (younger than slot 0)
- enq1_data  in  DATA_WIDTH  slot-1 payload
- enq1_cond  in  COND_WIDTH  slot-1 initial condition
- enq_ready  out  1  both slots accepted this cycle
- deq_valid  out  1  head entry ready to issue
- deq_ready  in  1  consumer accepts head
- deq_data  out  DATA_WIDTH  head payload
- deq_cond  out  COND_WIDTH  head condition
- wb_valid  in  NUM_WB  per-port wakeup valid
- wb_robid  in  NUM_WB*ROBID_WIDTH  packed wakeup ROB ids, port p at [p*ROBID_WIDTH +: ROBID_WIDTH]
- wb_mask  in  NUM_WB*COND_WIDTH  packed condition bits each port sets
- flush_valid  in  1  squash request
- flush_robid  in  ROBID_WIDTH  oldest squashed-excluded id; entries strictly younger are killed
- count  out  $clog2(DEPTH)+1  occupancy
- empty  out  1  count==0
- full  out  1  count==DEPTH

Behaviour:
- Reset state:
  - Async reset (reset_n low): head=0, tail=0, count=0, all entry valid/cond cleared.
  - Outputs at reset: enq_ready=1, deq_valid=0, empty=1, full=0, deq_data/deq_cond=0.
- Enqueue:
  - enq_ready = (DEPTH-count >= 2) && !flush_valid. Combinational; it does not depend on enq*_valid.
  - Enqueue fires when enq_ready and enqN_valid. Slot 0 is written at tail, slot 1 at tail+1 (mod DEPTH).
  - tail advances by the number of valid slots; count increases likewise. Data becomes visible at the head the next cycle (1-cycle latency).
  - enq1_valid without enq0_valid is illegal; the bench asserts on it.
- Condition update:
  - Each cycle, for every valid entry and every port p with wb_valid[p] and matching ROB id, cond |= wb_mask[p]. Multiple hitting ports OR together.
  - Same-cycle bypass: an entry enqueued in a cycle whose ROB id matches an active wakeup stores enqN_cond | wb_mask[p].
- Dequeue:
  - deq_valid = !empty && &head.cond && !flush_valid.
  - On deq_valid && deq_ready: head entry is invalidated, head = head+1 mod DEPTH, count decrements.
  - deq_data/deq_cond show the head entry regardless of deq_valid; they are 0 when empty.
  - Simultaneous enqueue and dequeue: count changes by (enqueued - 1). The full check uses pre-update count.
- Flush:
  - Youngerness of entry id e relative to flush id f: (e.wrap ^ f.wrap) ^ (e.idx > f.idx).
  - While flush_valid, enqueue and dequeue are blocked. Killed entries are invalidated in that cycle.
  - count <= number of surviving valid entries; tail <= head + survivors (mod DEPTH).
  - Survivors keep their position and condition; a wakeup in the flush cycle still applies to survivors.
  - flush_robid equal to an entry id does not kill that entry.
  - Flushing all entries leaves tail = head and empty=1.
- Wrap-around: head/tail wrap mod DEPTH. Full is derived from count, not from pointer equality.
- Reset mid-operation: discards all contents immediately; no entry survives.

Test Plan:
- Reset, then two-slot enqueue of ids 0x00/0x01 with cond=2'b11 -> next cycle count=2, deq_valid=1, deq_data[247:241]=0x00; deq_ready=1 for 2 cycles -> ids 0x00 then 0x01 dequeued, empty=1.
- Fill with count=7 (DEPTH=8) -> enq_ready=0. Dequeue one ready head -> count=6, enq_ready=1. Enqueue across index 7->0 -> FIFO order preserved after wrap.
- Head id 0x05 with cond=2'b01, wb_valid=2'b10, wb_robid port1=0x05, wb_mask port1=2'b10 -> head cond=2'b11, deq_valid=1 next cycle. A non-matching id leaves deq_valid=0.
- Enqueue id 0x09 with cond=2'b00 in the same cycle that wb port0 hits 0x09 with mask 2'b11 -> stored cond=2'b11.
- Queue holds ids 0x3E,0x3F,0x40,0x41 (wrap bit flips at 0x40); flush_robid=0x3F -> 0x40 and 0x41 killed, count=2, next enqueue lands at the slot after 0x3F.
- Flush with flush_robid older than every entry -> count=0, empty=1. Enqueue asserted in the flush cycle -> enq_ready=0, nothing written. Assert reset_n low while count=5 -> count=0, deq_valid=0 asynchronously.
